// File: rtl/enc3b4b_stage_pkg.sv
// Shared 8b/10b encoder package: code-table constants and small helpers.
// This package holds the 3b/4b sub-block tables for data (D.x.y) and control (K.x.y)
// symbols, for both running-disparity columns. The 5b/6b tables use the same package.
//   nib_t           4-bit encoded sub-block, bit3 = f (transmitted first), bit0 = j
//   cls_t           {S,K,HGF} word from the 3B/4B classification stage
//   nib_unbalanced  1 when a nibble has weight 1 or 3, so running disparity flips
package enc3b4b_stage_pkg;

  typedef logic [3:0] nib_t;

  typedef struct packed {
    logic       s;    // use the alternate D.x.7 (A7) encoding
    logic       k;    // control symbol
    logic [2:0] hgf;  // 3-bit sub-block value y of D.x.y / K.x.y
  } cls_t;

  // Data codes, indexed by HGF. RDN is used when rd6 is negative, RDP when it is positive.
  localparam nib_t D34_RDN [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                     4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam nib_t D34_RDP [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                     4'b0010, 4'b1010, 4'b0110, 4'b0001};
  // Alternate D.x.7 codes. They avoid a run of five equal bits across the sub-block boundary.
  localparam nib_t D34_ALT_RDN = 4'b0111;
  localparam nib_t D34_ALT_RDP = 4'b1000;

  // Control codes, indexed by HGF. S has no effect on these codes.
  localparam nib_t K34_RDN [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                                     4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam nib_t K34_RDP [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                     4'b0010, 4'b1010, 4'b0110, 4'b1000};

  // Odd parity of a nibble means its weight is 1 or 3. That is the unbalanced case.
  function automatic logic nib_unbalanced(input nib_t n);
    return ^n;
  endfunction

endpackage

// File: rtl/enc3b4b_stage_if.sv
// Handshake bundle for the 3b/4b encoder stage.
//   in side : in_valid, in_ready, data_buffer {S,K,H,G,F}, rd6_in
//   out side: out_valid, out_ready, fghj, rd_out
//   slave   = the encoder stage; master = upstream source plus downstream sink
interface enc3b4b_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] data_buffer;
  logic       rd6_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fghj;
  logic       rd_out;

  modport slave (
    input  in_valid, data_buffer, rd6_in, out_ready,
    output in_ready, out_valid, fghj, rd_out
  );

  modport master (
    output in_valid, data_buffer, rd6_in, out_ready,
    input  in_ready, out_valid, fghj, rd_out
  );
endinterface

// File: rtl/enc3b4b_lut.sv
// Combinational 3b/4b lookup.
//   s, k, hgf : classified symbol fields
//   rd6       : running disparity after the 6b sub-block (1 = positive)
//   fghj      : selected 4b code
//   flip      : 1 when fghj is unbalanced, so the running disparity inverts
module enc3b4b_lut
  import enc3b4b_stage_pkg::*;
(
  input  logic       s,
  input  logic       k,
  input  logic [2:0] hgf,
  input  logic       rd6,
  output logic [3:0] fghj,
  output logic       flip
);

  nib_t code_s;

  // Select the code: control table, then alternate D.x.7, otherwise the primary data table.
  always_comb begin
    code_s = 4'b0000;
    if (k) begin
      code_s = rd6 ? K34_RDP[hgf] : K34_RDN[hgf];
    end else if (s && (hgf == 3'd7)) begin
      code_s = rd6 ? D34_ALT_RDP : D34_ALT_RDN;
    end else begin
      code_s = rd6 ? D34_RDP[hgf] : D34_RDN[hgf];
    end
  end

  assign fghj = code_s;
  assign flip = nib_unbalanced(code_s);

endmodule

// File: rtl/enc3b4b_stage.sv
// 3b/4b encoder pipeline stage with a one-entry output register and a transfer counter.
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low reset
//   bus     : handshake bundle (slave side); in_ready = ~out_valid | out_ready
//   sym_cnt : number of nibbles accepted since reset (wraps)
// The stage encodes only from the incoming rd6_in. It never feeds back its own rd_out.
module enc3b4b_stage
  import enc3b4b_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  enc3b4b_stage_if.slave        bus,
  output logic [15:0]           sym_cnt
);

  cls_t       cls_s;
  logic [3:0] lut_fghj_s;
  logic       lut_flip_s;
  logic       xfer_s;

  logic       out_valid_r;
  logic [3:0] fghj_r;
  logic       rd_out_r;
  logic [15:0] sym_cnt_r;

  assign cls_s  = cls_t'(bus.data_buffer);
  // The stage can accept a symbol when the holding register is empty or is draining this cycle.
  assign bus.in_ready = ~out_valid_r | bus.out_ready;
  assign xfer_s       = bus.in_valid & bus.in_ready;

  enc3b4b_lut u_lut (
    .s    (cls_s.s),
    .k    (cls_s.k),
    .hgf  (cls_s.hgf),
    .rd6  (bus.rd6_in),
    .fghj (lut_fghj_s),
    .flip (lut_flip_s)
  );

  // Output holding register and counter. Load on transfer, clear valid on drain, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      fghj_r      <= 4'b0000;
      rd_out_r    <= 1'b0;
      sym_cnt_r   <= 16'h0000;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      fghj_r      <= lut_fghj_s;
      rd_out_r    <= bus.rd6_in ^ lut_flip_s;
      sym_cnt_r   <= sym_cnt_r + 16'd1;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.fghj      = fghj_r;
  assign bus.rd_out    = rd_out_r;
  assign sym_cnt       = sym_cnt_r;

endmodule

// File: tb/tb_enc3b4b_stage.sv
// Scoreboard bench for enc3b4b_stage: random and directed stimulus checked against a table model.
module tb_enc3b4b_stage;

  logic        clk;
  logic        reset;
  logic [15:0] sym_cnt;
  int          checks;
  int          failures;
  logic [4:0]  exp_q[$];
  logic [15:0] exp_cnt;

  enc3b4b_stage_if bus();

  enc3b4b_stage dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .sym_cnt (sym_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tables: [HGF][rd6], with rd6 = 0 in the first column. The alternate D.x.7 code is handled in the model.
  localparam logic [3:0] DTAB [8][2] = '{'{4'b1011, 4'b0100}, '{4'b1001, 4'b1001},
                                         '{4'b0101, 4'b0101}, '{4'b1100, 4'b0011},
                                         '{4'b1101, 4'b0010}, '{4'b1010, 4'b1010},
                                         '{4'b0110, 4'b0110}, '{4'b1110, 4'b0001}};
  localparam logic [3:0] KTAB [8][2] = '{'{4'b1011, 4'b0100}, '{4'b0110, 4'b1001},
                                         '{4'b1010, 4'b0101}, '{4'b1100, 4'b0011},
                                         '{4'b1101, 4'b0010}, '{4'b0101, 4'b1010},
                                         '{4'b1001, 4'b0110}, '{4'b0111, 4'b1000}};

  // Returns {fghj, rd_out} for one symbol.
  function automatic logic [4:0] model(input logic [4:0] db, input logic rd6);
    logic [3:0] f;
    int         y;
    y = int'(db[2:0]);
    if (db[3])
      f = KTAB[y][int'(rd6)];
    else if (y == 7 && db[4])
      f = rd6 ? 4'b1000 : 4'b0111;
    else
      f = DTAB[y][int'(rd6)];
    return {f, ($countones(f) == 2) ? rd6 : ~rd6};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: checks occupancy and the counter, pops on drain, and pushes the model result on accept.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_cnt = 16'h0000;
    end else begin
      chk("occupancy", {15'd0, bus.out_valid}, {15'd0, exp_q.size() != 0});
      chk("sym_cnt", sym_cnt, exp_cnt);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("underflow", 16'd1, 16'd0);
        end else begin
          chk("nibble", {11'd0, bus.fghj, bus.rd_out}, {11'd0, exp_q.pop_front()});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.data_buffer, bus.rd6_in));
        exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] db, input logic rd, input logic ordy);
    bus.in_valid    = v;
    bus.data_buffer = db;
    bus.rd6_in      = rd;
    bus.out_ready   = ordy;
  endtask

  // Sends one symbol into an empty stage and checks the registered result one cycle later.
  task automatic send_check(input string name, input logic [4:0] db, input logic rd,
                            input logic [3:0] ef, input logic er);
    @(posedge clk); #1 drive(1'b1, db, rd, 1'b1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    chk({name, "_fghj"}, {12'd0, bus.fghj}, {12'd0, ef});
    chk({name, "_rd"}, {15'd0, bus.rd_out}, {15'd0, er});
    chk({name, "_valid"}, {15'd0, bus.out_valid}, 16'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0]  held_f;
    logic [15:0] held_c;
    logic [4:0]  d;
    checks = 0;
    failures = 0;
    exp_cnt = 16'h0000;
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    chk("rst_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_fghj", {12'd0, bus.fghj}, 16'd0);
    chk("rst_rd", {15'd0, bus.rd_out}, 16'd0);
    chk("rst_cnt", sym_cnt, 16'd0);
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;

    send_check("dx0_n", 5'b00000, 1'b0, 4'b1011, 1'b1);
    send_check("dx0_p", 5'b00000, 1'b1, 4'b0100, 1'b0);
    send_check("dx7_alt", 5'b10111, 1'b0, 4'b0111, 1'b1);
    send_check("dx7_pri", 5'b00111, 1'b0, 4'b1110, 1'b1);
    send_check("k28_5_n", 5'b01101, 1'b0, 4'b0101, 1'b0);
    send_check("k28_5_p", 5'b01101, 1'b1, 4'b1010, 1'b1);

    // Stall: load one nibble, then hold out_ready low for five cycles with input pending.
    d = 5'($urandom_range(31, 0));
    drive(1'b1, d, 1'b0, 1'b0);
    held_f = model(d, 1'b0) >> 1;
    @(posedge clk); #1 drive(1'b1, 5'($urandom_range(31, 0)), 1'($urandom), 1'b0);
    held_c = exp_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", {15'd0, bus.in_ready}, 16'd0);
      chk("stall_fghj", {12'd0, bus.fghj}, {12'd0, held_f});
      chk("stall_cnt", sym_cnt, held_c);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("b2b_valid", {15'd0, bus.out_valid}, 16'd1);
      chk("b2b_cnt", sym_cnt, held_c + 16'(i + 1));
      drive(1'b1, 5'($urandom_range(31, 0)), 1'($urandom), 1'b1);
    end

    // Random traffic with random back-pressure.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1 drive(1'($urandom), 5'($urandom_range(31, 0)), 1'($urandom),
                               ($urandom_range(3, 0) != 0));
    end

    // Exhaustive sweep of every symbol and both disparities, one per cycle.
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1 drive(1'b1, 5'(i >> 1), 1'(i), 1'b1);
    end
    @(posedge clk); #1 drive(1'b0, 5'd0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("drain_empty", 16'(exp_q.size()), 16'd0);

    // Reset in the middle of a held nibble.
    drive(1'b1, 5'b00000, 1'b0, 1'b0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("mid_rst_fghj", {12'd0, bus.fghj}, 16'd0);
    chk("mid_rst_rd", {15'd0, bus.rd_out}, 16'd0);
    chk("mid_rst_cnt", sym_cnt, 16'd0);
    chk("mid_rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    bus.out_ready = 1'b1;

    // Counter wrap: 65535 transfers, then one more.
    @(posedge clk); #1 drive(1'b1, 5'($urandom_range(31, 0)), 1'($urandom), 1'b1);
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk); #1 drive(1'b1, 5'($urandom_range(31, 0)), 1'($urandom), 1'b1);
    end
    chk("cnt_ffff", sym_cnt, 16'hFFFF);
    @(posedge clk); #1 drive(1'b0, 5'd0, 1'b0, 1'b1);
    chk("cnt_wrap", sym_cnt, 16'h0000);
    repeat (3) @(posedge clk);
    #1 chk("final_empty", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enc3b4b_stage.md
ENC3B4B_STAGE -- requirements
Module: enc3b4b_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  data_buffer/rd6_in carry a symbol this cycle.
REQ-004 in_ready  output  1  stage accepts the symbol this cycle.
REQ-005 data_buffer  input  5  {S,K,H,G,F} from the 3B/4B classification stage; S selects alternate D.x.7.
REQ-006 rd6_in  input  1  running disparity after the 6b sub-block of the same symbol (1 = positive, 0 = negative).
REQ-007 out_valid  output  1  fghj/rd_out hold a valid encoded nibble.
REQ-008 out_ready  input  1  downstream serializer accepts the nibble this cycle.
REQ-009 fghj  output  4  encoded 4b sub-block; bit3 = f (transmitted first), bit0 = j.
REQ-010 rd_out  output  1  running disparity after the 4b sub-block (1 = positive).
REQ-011 sym_cnt  output  16  count of nibbles accepted since reset.

Function
REQ-012 in_ready SHALL equal (~out_valid | out_ready), combinationally.
REQ-013 A transfer SHALL occur when in_valid & in_ready; fghj, rd_out and out_valid SHALL update on that clk edge (latency 1 cycle).
REQ-014 If out_valid & ~out_ready, fghj/rd_out/out_valid SHALL hold unchanged regardless of in_valid.
REQ-015 If out_ready & ~in_valid while out_valid, out_valid SHALL clear on the next edge; fghj/rd_out SHALL hold their last values.
REQ-016 Data codes (K=0), HGF -> fghj for rd6_in=0 / rd6_in=1: 000 1011/0100; 001 1001/1001; 010 0101/0101; 011 1100/0011; 100 1101/0010; 101 1010/1010; 110 0110/0110; 111 with S=0 1110/0001; 111 with S=1 0111/1000.
REQ-017 Control codes (K=1), HGF -> fghj for rd6_in=0 / rd6_in=1: 000 1011/0100; 001 0110/1001; 010 1010/0101; 011 1100/0011; 100 1101/0010; 101 0101/1010; 110 1001/0110; 111 0111/1000 (S ignored).
REQ-018 rd_out SHALL equal ~rd6_in when the selected fghj has unequal ones/zeros (weight 1 or 3), else rd6_in.
REQ-019 Encoding SHALL be a pure function of the accepted data_buffer and rd6_in; the block SHALL NOT use its own prior rd_out for encoding.
REQ-020 A code of weight 1 SHALL only be emitted with rd6_in=1 and weight 3 only with rd6_in=0; any accepted input otherwise SHALL be impossible by REQ-016/017 and is an assertion target.
REQ-021 sym_cnt SHALL increment by 1 on each transfer and wrap from 16'hFFFF to 16'h0000.
REQ-022 Simultaneous output drain and new transfer (out_valid & out_ready & in_valid) SHALL load the new nibble with out_valid remaining 1, no bubble.

Reset
REQ-023 While reset=0: out_valid=0, fghj=4'b0000, rd_out=0, sym_cnt=0, independent of clk.
REQ-024 Reset asserted mid-transfer SHALL discard the held nibble; in_ready SHALL read 1 during and after reset.
REQ-025 Reset release SHALL take effect on the first rising clk edge after reset=1; no transfer before that edge.

Structure
REQ-026 The 3b/4b code table constants (data/control, both disparities) SHALL reside in the shared 8b/10b package alongside the 5b/6b table.
REQ-027 One combinational sub-module, enc3b4b_lut (inputs S,K,HGF,rd6; outputs fghj, flip), SHALL hold the table; enc3b4b_stage holds handshake, registers and counter.

Verification
REQ-028 D.x.0, rd6_in=0, transfer -> next cycle fghj=1011, rd_out=1, out_valid=1; same with rd6_in=1 -> fghj=0100, rd_out=0.
REQ-029 data_buffer=5'b10111 (S=1,D.x.7), rd6_in=0 -> fghj=0111, rd_out=1; S=0 -> fghj=1110.
REQ-030 K.28.5 nibble (K=1,HGF=101), rd6_in=0 -> fghj=0101, rd_out=0; rd6_in=1 -> 1010, rd_out=1.
REQ-031 out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, fghj stable, sym_cnt unchanged; out_ready=1 -> back-to-back transfers, one per cycle, no bubble.
REQ-032 Exhaustive sweep of all 32 data_buffer x 2 rd6_in values against REQ-016/017/018 model; preload 16'hFFFF transfers -> sym_cnt wraps to 0.
REQ-033 Assert reset=0 while out_valid=1 and out_ready=0 -> immediately out_valid=0, fghj=0000, rd_out=0, sym_cnt=0.
